// File: rtl/decode_issue_unit.sv
// RV32IMF ID-stage decoder with a registered output stage and a stall FSM
// that holds issue off while a MUL/DIV/FPU operation occupies EX.
module decode_issue_unit #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 16,
  parameter int FPU_LATENCY = 4,
  parameter int CNT_W = $clog2(((MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY) > FPU_LATENCY ?
                               ((MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY) : FPU_LATENCY) + 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [5:0]  alu_signal,
  output logic        reg_file_write,
  output logic [2:0]  main_mem_write,
  output logic [3:0]  main_mem_read,
  output logic [3:0]  branch_control,
  output logic [3:0]  immediate_select,
  output logic        oparand_1_select,
  output logic        oparand_2_select,
  output logic [1:0]  reg_write_select,
  output logic        mc_busy,
  output logic        illegal
);

  typedef enum logic [1:0] {CLS_NONE, CLS_MUL, CLS_DIV, CLS_FPU} class_e;
  typedef enum logic {IDLE, MC_WAIT} state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FP     = 7'b1010011;

  localparam logic [CNT_W-1:0] MUL_WAIT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_WAIT = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] FPU_WAIT = CNT_W'(FPU_LATENCY - 1);

  logic [6:0]       w_opcode, w_funct7;
  logic [2:0]       w_funct3;
  logic [5:0]       w_alu;
  logic             w_rfw, w_op1, w_op2, w_illegal;
  logic [2:0]       w_mw;
  logic [3:0]       w_mr, w_br, w_imm;
  logic [1:0]       w_rws;
  class_e           w_class, r_class;
  state_e           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt, w_wait;
  logic             w_accept, w_handoff;

  assign w_opcode = INSTRUCTION[6:0];
  assign w_funct3 = INSTRUCTION[14:12];
  assign w_funct7 = INSTRUCTION[31:25];

  assign in_ready  = ~RESET & ~flush & (r_state == IDLE) & (~out_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_handoff = out_valid & out_ready;

  // Immediate codes: 1=I 2=S 3=B 4=U 5=J; write-back: 0=ALU 1=mem 2=PC+4 3=FPU
  always_comb begin
    w_alu = '0; w_rfw = 1'b0; w_mw = '0; w_mr = '0; w_br = '0; w_imm = '0;
    w_op1 = 1'b0; w_op2 = 1'b0; w_rws = '0; w_illegal = 1'b0; w_class = CLS_NONE;
    if (INSTRUCTION != 32'd0) begin
      case (w_opcode)
        OP_LOAD:   begin w_rfw = 1'b1; w_mr = {1'b1, w_funct3}; w_imm = 4'd1; w_op2 = 1'b1; w_rws = 2'd1; end
        OP_IMM:    begin w_alu = {2'b00, (w_funct3 == 3'b101) & w_funct7[5], w_funct3};
                         w_rfw = 1'b1; w_imm = 4'd1; w_op2 = 1'b1; end
        OP_AUIPC:  begin w_rfw = 1'b1; w_imm = 4'd4; w_op1 = 1'b1; w_op2 = 1'b1; end
        OP_STORE:  begin w_mw = {1'b1, w_funct3[1:0]}; w_imm = 4'd2; w_op2 = 1'b1; end
        OP_REG:    begin w_alu = {1'b0, w_funct7[0], w_funct7[5], w_funct3}; w_rfw = 1'b1;
                         if (w_funct7 == 7'b0000001) w_class = w_funct3[2] ? CLS_DIV : CLS_MUL; end
        OP_LUI:    begin w_alu = 6'b011111; w_rfw = 1'b1; w_imm = 4'd4; w_op2 = 1'b1; end
        OP_BRANCH: begin w_br = {1'b1, w_funct3}; w_imm = 4'd3; w_op1 = 1'b1; w_op2 = 1'b1; end
        OP_JALR:   begin w_br = 4'b1011; w_rfw = 1'b1; w_imm = 4'd1; w_op2 = 1'b1; w_rws = 2'd2; end
        OP_JAL:    begin w_br = 4'b1010; w_rfw = 1'b1; w_imm = 4'd5; w_op1 = 1'b1; w_op2 = 1'b1; w_rws = 2'd2; end
        OP_FP:     begin w_alu = {1'b1, w_funct7[6:2]}; w_rfw = 1'b1; w_rws = 2'd3; w_class = CLS_FPU; end
        default:   begin w_illegal = 1'b1; w_rfw = 1'b0; w_mw[2] = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid <= 1'b0; alu_signal <= '0; reg_file_write <= 1'b0; main_mem_write <= '0;
      main_mem_read <= '0; branch_control <= '0; immediate_select <= '0; oparand_1_select <= 1'b0;
      oparand_2_select <= 1'b0; reg_write_select <= '0; illegal <= 1'b0; r_class <= CLS_NONE;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1; alu_signal <= w_alu; reg_file_write <= w_rfw; main_mem_write <= w_mw;
      main_mem_read <= w_mr; branch_control <= w_br; immediate_select <= w_imm; oparand_1_select <= w_op1;
      oparand_2_select <= w_op2; reg_write_select <= w_rws; illegal <= w_illegal; r_class <= w_class;
    end else if (w_handoff) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    case (r_class)
      CLS_MUL: w_wait = MUL_WAIT;
      CLS_DIV: w_wait = DIV_WAIT;
      CLS_FPU: w_wait = FPU_WAIT;
      default: w_wait = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // A zero wait (no class, or latency 1) keeps the FSM in IDLE
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (flush) begin
      w_next_state = IDLE;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        IDLE: if (w_handoff && (w_wait != '0)) begin
          w_next_state = MC_WAIT;
          w_next_cnt   = w_wait;
        end
        MC_WAIT: begin
          w_next_cnt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    mc_busy = (r_state == MC_WAIT);
  end

endmodule
